// File: rtl/ro_freq_counter.sv
// Purpose: ring-oscillator frequency counter; counts synchronised rising edges of one selected tap over a 2^GATE_LOG2 cycle gate.
// Latency: DONE, COUNT, OVF and BUSY=0 appear after edge E(3+2^GATE_LOG2), where E0 is the edge that accepts START.
// Backpressure: none; START is ignored while BUSY=1, and COUNT/OVF hold until the next window completes.
//
// Ports:
//   CLK    system clock, rising edge
//   RN     asynchronous active-low reset
//   START  measurement request, accepted in IDLE only
//   SEL    oscillator select, captured on the START-accept edge (>= N_RO selects constant 0)
//   RO_IN  free-running oscillator outputs, asynchronous to CLK
//   BUSY   high from START-accept until the result is published
//   DONE   one-cycle pulse, COUNT/OVF just updated
//   COUNT  rising edges counted in the last completed window (saturating)
//   OVF    last window lost edges because COUNT was saturated
module ro_freq_counter #(
    parameter int N_RO      = 6,
    parameter int SEL_W     = 3,
    parameter int GATE_LOG2 = 10,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic [SEL_W-1:0] SEL,
    input  logic [N_RO-1:0]  RO_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state;
    logic [SEL_W-1:0]     sel_q;
    logic [1:0]           arm_cnt;
    logic [GATE_LOG2-1:0] win;
    logic [CNT_W-1:0]     cnt;
    logic                 ovf_q;
    logic                 s1, s2, s3;
    logic                 ro;
    logic                 ro_edge;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 ovf_nxt;

    // Compare-based mux so out-of-range selections never index past RO_IN.
    always_comb begin
        ro = 1'b0;
        for (int i = 0; i < N_RO; i++) begin
            if (sel_q == SEL_W'(i)) begin
                ro = RO_IN[i];
            end
        end
    end

    // s1/s2 are the metastability synchroniser; s3 only delays s2 for edge detection.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= ro;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign ro_edge = s2 & ~s3;

    // Saturating increment; an edge arriving while already saturated is a lost edge.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf_q;
        if (ro_edge) begin
            if (cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state   <= IDLE;
            sel_q   <= '0;
            arm_cnt <= '0;
            win     <= '0;
            cnt     <= '0;
            ovf_q   <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            COUNT   <= '0;
            OVF     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        sel_q   <= SEL;
                        BUSY    <= 1'b1;
                        arm_cnt <= '0;
                        state   <= ARM;
                    end
                end
                // Three cycles let the new selection propagate through s1..s3,
                // so the first MEASURE sample never sees a stale-tap edge.
                ARM: begin
                    arm_cnt <= arm_cnt + 1'b1;
                    win     <= '0;
                    cnt     <= '0;
                    ovf_q   <= 1'b0;
                    if (arm_cnt == 2'd2) begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    cnt   <= cnt_nxt;
                    ovf_q <= ovf_nxt;
                    win   <= win + 1'b1;
                    // Last sample of the window is folded straight into the result.
                    if (&win) begin
                        COUNT <= cnt_nxt;
                        OVF   <= ovf_nxt;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Purpose: self-checking bench for ro_freq_counter (default instance plus a narrow-counter instance).
// Latency: expects DONE exactly 1027 cycles after the START-accept edge.
// Backpressure: START pulses while BUSY must be ignored.
module tb_ro_freq_counter;

    logic        CLK = 1'b0;
    logic        RN;
    logic        START_a, START_b;
    logic [2:0]  SEL;
    logic [5:0]  RO_IN;
    logic        BUSY_a, DONE_a, OVF_a;
    logic [15:0] COUNT_a;
    logic        BUSY_b, DONE_b, OVF_b;
    logic [5:0]  COUNT_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_cnt_a = 0;
    int half[6];
    int ph[6];

    typedef struct {
        int lo;
        int hi;
        bit ovf;
    } exp_t;
    exp_t sb_q[$];

    ro_freq_counter dut_a (
        .CLK(CLK), .RN(RN), .START(START_a), .SEL(SEL), .RO_IN(RO_IN),
        .BUSY(BUSY_a), .DONE(DONE_a), .COUNT(COUNT_a), .OVF(OVF_a)
    );

    ro_freq_counter #(.N_RO(6), .SEL_W(3), .GATE_LOG2(10), .CNT_W(6)) dut_b (
        .CLK(CLK), .RN(RN), .START(START_b), .SEL(SEL), .RO_IN(RO_IN),
        .BUSY(BUSY_b), .DONE(DONE_b), .COUNT(COUNT_b), .OVF(OVF_b)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (DONE_a) done_cnt_a <= done_cnt_a + 1;
    end

    // Oscillator model: half-period in CLK cycles, 0 = stuck low.
    initial begin
        RO_IN = '0;
        for (int i = 0; i < 6; i++) begin
            half[i] = 0;
            ph[i]   = 0;
        end
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 6; i++) begin
                if (half[i] == 0) begin
                    RO_IN[i] = 1'b0;
                    ph[i]    = 0;
                end else begin
                    ph[i] = ph[i] + 1;
                    if (ph[i] >= half[i]) begin
                        ph[i]    = 0;
                        RO_IN[i] = ~RO_IN[i];
                    end
                end
            end
        end
    end

    task automatic start_run(input bit b, input logic [2:0] s, output int e0);
        @(negedge CLK);
        SEL = s;
        if (b) START_b = 1'b1;
        else   START_a = 1'b1;
        e0 = cyc + 1;
        @(negedge CLK);
        START_a = 1'b0;
        START_b = 1'b0;
    endtask

    task automatic wait_done(input bit b, output bit found, output int at);
        found = 1'b0;
        at    = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge CLK);
            if ((b ? DONE_b : DONE_a) === 1'b1) begin
                found = 1'b1;
                at    = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        RN = 1'b1; START_a = 1'b0; START_b = 1'b0; SEL = '0;
        #3 RN = 1'b0;
        #10;
        checks++;
        if ({BUSY_a, DONE_a, OVF_a, COUNT_a} !== 19'd0) begin
            errors++;
            $display("FAIL reset_assert: busy=%b done=%b ovf=%b count=%0d, want all 0", BUSY_a, DONE_a, OVF_a, COUNT_a);
        end
        @(negedge CLK);
        RN = 1'b1;
        bad = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge CLK);
            checks++;
            if ({BUSY_a, DONE_a, OVF_a, COUNT_a, BUSY_b, DONE_b, OVF_b, COUNT_b} !== 28'd0) begin
                errors++;
                if (bad < 5) $display("FAIL reset_idle cyc %0d: a=%b%b%b/%0d b=%b%b%b/%0d, want 0", cyc,
                                      BUSY_a, DONE_a, OVF_a, COUNT_a, BUSY_b, DONE_b, OVF_b, COUNT_b);
                bad++;
            end
        end
    endtask

    task automatic test_basic();
        int e0, at; bit found; exp_t e;
        half[1] = 4;
        start_run(1'b0, 3'd1, e0);
        sb_q.push_back('{127, 129, 1'b0});
        checks++;
        if (BUSY_a !== 1'b1) begin errors++; $display("FAIL basic_busy: busy=%b want 1", BUSY_a); end
        wait_done(1'b0, found, at);
        e = sb_q.pop_front();
        checks++;
        if (!found || at !== e0 + 1027) begin
            errors++; $display("FAIL basic_latency: found=%b at=%0d want %0d", found, at, e0 + 1027);
        end
        checks++;
        if (int'(COUNT_a) < e.lo || int'(COUNT_a) > e.hi) begin
            errors++; $display("FAIL basic_count: got %0d want %0d..%0d", COUNT_a, e.lo, e.hi);
        end
        checks++;
        if (OVF_a !== e.ovf) begin errors++; $display("FAIL basic_ovf: got %b want %b", OVF_a, e.ovf); end
        @(negedge CLK);
        checks++;
        if ({DONE_a, BUSY_a} !== 2'b00) begin
            errors++; $display("FAIL basic_done_pulse: done=%b busy=%b want 0 0", DONE_a, BUSY_a);
        end
    endtask

    task automatic test_select();
        int e0, at; bit found; exp_t e;
        for (int i = 0; i < 6; i++) half[i] = 3;
        half[2] = 0;
        start_run(1'b0, 3'd2, e0);
        sb_q.push_back('{0, 0, 1'b0});
        wait_done(1'b0, found, at);
        e = sb_q.pop_front();
        checks++;
        if (!found || int'(COUNT_a) < e.lo || int'(COUNT_a) > e.hi || OVF_a !== e.ovf) begin
            errors++; $display("FAIL sel_stuck: found=%b count=%0d ovf=%b want 0 0", found, COUNT_a, OVF_a);
        end
        half[2] = 3;
        start_run(1'b0, 3'd7, e0);
        sb_q.push_back('{0, 0, 1'b0});
        wait_done(1'b0, found, at);
        e = sb_q.pop_front();
        checks++;
        if (!found || int'(COUNT_a) < e.lo || int'(COUNT_a) > e.hi || OVF_a !== e.ovf) begin
            errors++; $display("FAIL sel_out_of_range: found=%b count=%0d ovf=%b want 0 0", found, COUNT_a, OVF_a);
        end
    endtask

    task automatic test_overflow();
        int e0, at; bit found; exp_t e;
        half[1] = 2;
        start_run(1'b1, 3'd1, e0);
        sb_q.push_back('{63, 63, 1'b1});
        wait_done(1'b1, found, at);
        e = sb_q.pop_front();
        checks++;
        if (!found || int'(COUNT_b) < e.lo || int'(COUNT_b) > e.hi || OVF_b !== e.ovf) begin
            errors++; $display("FAIL ovf_sat: found=%b count=%0d ovf=%b want 63 1", found, COUNT_b, OVF_b);
        end
        half[1] = 0;
        start_run(1'b1, 3'd1, e0);
        sb_q.push_back('{0, 0, 1'b0});
        wait_done(1'b1, found, at);
        e = sb_q.pop_front();
        checks++;
        if (!found || int'(COUNT_b) < e.lo || int'(COUNT_b) > e.hi || OVF_b !== e.ovf) begin
            errors++; $display("FAIL ovf_clear: found=%b count=%0d ovf=%b want 0 0", found, COUNT_b, OVF_b);
        end
    endtask

    task automatic test_back_to_back();
        int e0, e0b, at, d0; bit found; exp_t e; logic [15:0] held;
        half[1] = 4;
        d0 = done_cnt_a;
        start_run(1'b0, 3'd1, e0);
        sb_q.push_back('{127, 129, 1'b0});
        held = COUNT_a;
        for (int k = 0; k < 20; k++) begin
            repeat (40) @(negedge CLK);
            SEL = 3'd7;
            START_a = 1'b1;
            @(negedge CLK);
            START_a = 1'b0;
        end
        checks++;
        if (COUNT_a !== held || BUSY_a !== 1'b1) begin
            errors++; $display("FAIL b2b_hold: count=%0d busy=%b want %0d 1", COUNT_a, BUSY_a, held);
        end
        wait_done(1'b0, found, at);
        e = sb_q.pop_front();
        checks++;
        if (!found || at !== e0 + 1027) begin
            errors++; $display("FAIL b2b_latency1: found=%b at=%0d want %0d", found, at, e0 + 1027);
        end
        checks++;
        if (int'(COUNT_a) < e.lo || int'(COUNT_a) > e.hi) begin
            errors++; $display("FAIL b2b_count1: got %0d want %0d..%0d", COUNT_a, e.lo, e.hi);
        end
        // START asserted during the DONE cycle.
        SEL = 3'd1;
        START_a = 1'b1;
        e0b = cyc + 1;
        sb_q.push_back('{127, 129, 1'b0});
        @(negedge CLK);
        START_a = 1'b0;
        checks++;
        if (BUSY_a !== 1'b1 || done_cnt_a !== d0 + 1) begin
            errors++; $display("FAIL b2b_restart: busy=%b dones=%0d want 1 %0d", BUSY_a, done_cnt_a - d0, 1);
        end
        wait_done(1'b0, found, at);
        e = sb_q.pop_front();
        checks++;
        if (!found || at !== e0b + 1027) begin
            errors++; $display("FAIL b2b_latency2: found=%b at=%0d want %0d", found, at, e0b + 1027);
        end
        checks++;
        if (int'(COUNT_a) < e.lo || int'(COUNT_a) > e.hi || OVF_a !== e.ovf) begin
            errors++; $display("FAIL b2b_count2: got %0d/%b want %0d..%0d/0", COUNT_a, OVF_a, e.lo, e.hi);
        end
    endtask

    task automatic test_abort();
        int e0, d0;
        start_run(1'b0, 3'd1, e0);
        repeat (500) @(negedge CLK);
        #2 RN = 1'b0;
        #1;
        checks++;
        if ({BUSY_a, DONE_a, OVF_a, COUNT_a} !== 19'd0) begin
            errors++; $display("FAIL abort_async: busy=%b done=%b ovf=%b count=%0d want 0", BUSY_a, DONE_a, OVF_a, COUNT_a);
        end
        @(negedge CLK);
        RN = 1'b1;
        d0 = done_cnt_a;
        repeat (1200) @(negedge CLK);
        checks++;
        if (done_cnt_a !== d0 || BUSY_a !== 1'b0 || COUNT_a !== 16'd0) begin
            errors++; $display("FAIL abort_no_done: dones=%0d busy=%b count=%0d want 0 0 0", done_cnt_a - d0, BUSY_a, COUNT_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_select();
        test_overflow();
        test_back_to_back();
        test_abort();
        checks++;
        if (sb_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
